// File: rtl/gfx_pkg.sv
// Shared graphics definitions: default raster geometry and write-sink FSM encoding.
package gfx_pkg;

  localparam int unsigned COLOR_DEPTH_DEF = 9;
  localparam int unsigned DRAW_WIDTH_DEF  = 640;
  localparam int unsigned DRAW_HEIGHT_DEF = 480;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_COMMIT = 3'd4
  } sink_state_e;

  // Width of a select/index field for n items, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Framebuffer address generator.
// Registers the bus coordinates and active flag, range-checks them and forms
// the linear pixel address {bank, y*DRAW_WIDTH+x}.
// Ports:
//   clk, resetN   clock, async active-low reset
//   sample_en     capture bus inputs this cycle (otherwise delay regs clear)
//   write_en      allow fb_we to assert
//   bank          bank bit placed in the address MSB
//   active/x_addr/y_addr  raw bus inputs
//   act_d         registered active flag
//   pixel_valid   act_d with in-range registered coordinates
//   fb_we/fb_addr framebuffer write strobe and address
module fb_addr_gen
  import gfx_pkg::*;
#(
  parameter int unsigned DRAW_WIDTH  = DRAW_WIDTH_DEF,
  parameter int unsigned DRAW_HEIGHT = DRAW_HEIGHT_DEF,
  parameter int unsigned ADDR_W      = $clog2(DRAW_WIDTH * DRAW_HEIGHT) + 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              sample_en,
  input  logic              write_en,
  input  logic              bank,
  input  logic              active,
  input  logic [31:0]       x_addr,
  input  logic [31:0]       y_addr,
  output logic              act_d,
  output logic              pixel_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr
);

  localparam int unsigned PIX_W = ADDR_W - 1;

  logic [31:0]      x_d;
  logic [31:0]      y_d;
  logic             in_range;
  logic [PIX_W-1:0] lin_addr;

  // Bus delay registers; cleared outside the sampling window so a floating bus has no effect.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act_d <= 1'b0;
      x_d   <= 32'd0;
      y_d   <= 32'd0;
    end else if (sample_en) begin
      act_d <= active;
      x_d   <= x_addr;
      y_d   <= y_addr;
    end else begin
      act_d <= 1'b0;
      x_d   <= 32'd0;
      y_d   <= 32'd0;
    end
  end

  // Range check and constant multiply-add; address forced to zero when not writing.
  always_comb begin
    in_range    = (x_d < 32'(DRAW_WIDTH)) && (y_d < 32'(DRAW_HEIGHT));
    pixel_valid = act_d && in_range;
    fb_we       = pixel_valid && write_en;
    lin_addr    = PIX_W'(y_d) * PIX_W'(DRAW_WIDTH) + PIX_W'(x_d);
    fb_addr     = fb_we ? {bank, lin_addr} : '0;
  end

endmodule

// File: rtl/fb_write_sink.sv
// Receiving end of the shared draw-source write bus.
// Grants one source a frame, captures its raster stream into the back bank of a
// double-buffered framebuffer and swaps banks when the stream ends.
// Ports:
//   clk, resetN                 clock, async active-low reset
//   frame_tick, src_req         frame start request and source to grant
//   write_source_sel            bus source select (held for the whole frame)
//   write_awaited               one-cycle grant pulse
//   write_active/color/x/y      raster stream from the selected source
//   fb_we/fb_addr/fb_wdata      framebuffer write port
//   fb_front_bank               bank currently displayed
//   frame_done                  one-cycle pulse on bank swap
//   frame_error                 sticky pixel-count or timeout error, cleared on grant
//   busy                        FSM not idle
module fb_write_sink
  import gfx_pkg::*;
#(
  parameter  int unsigned NUM_SOURCES = 2,
  parameter  int unsigned COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter  int unsigned DRAW_WIDTH  = DRAW_WIDTH_DEF,
  parameter  int unsigned DRAW_HEIGHT = DRAW_HEIGHT_DEF,
  parameter  int unsigned TIMEOUT     = 1024,
  localparam int unsigned SEL_W       = sel_width(NUM_SOURCES),
  localparam int unsigned ADDR_W      = $clog2(DRAW_WIDTH * DRAW_HEIGHT) + 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_tick,
  input  logic [SEL_W-1:0]       src_req,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic                   write_awaited,
  input  logic                   write_active,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic [31:0]            write_x_addr,
  input  logic [31:0]            write_y_addr,
  output logic                   fb_we,
  output logic [ADDR_W-1:0]      fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_wdata,
  output logic                   fb_front_bank,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int unsigned NUM_PIX = DRAW_WIDTH * DRAW_HEIGHT;
  localparam int unsigned CNT_W   = $clog2(NUM_PIX + 1);
  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sink_state_e      state;
  logic [CNT_W-1:0] pix_cnt;
  logic [TIMER_W-1:0] timer;
  logic             act_d;
  logic             pixel_valid;
  logic             sample_en;
  logic             write_en;

  assign sample_en = (state == S_WAIT) || (state == S_STREAM);
  assign write_en  = (state == S_STREAM);

  fb_addr_gen #(
    .DRAW_WIDTH  (DRAW_WIDTH),
    .DRAW_HEIGHT (DRAW_HEIGHT),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .resetN      (resetN),
    .sample_en   (sample_en),
    .write_en    (write_en),
    .bank        (~fb_front_bank),
    .active      (write_active),
    .x_addr      (write_x_addr),
    .y_addr      (write_y_addr),
    .act_d       (act_d),
    .pixel_valid (pixel_valid),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr)
  );

  // Color lags coordinates by one cycle, so the current bus color belongs to the registered pixel.
  assign fb_wdata = fb_we ? write_color_data : '0;

  // Frame sequencing FSM with registered status outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= S_IDLE;
      write_source_sel <= '0;
      write_awaited    <= 1'b0;
      fb_front_bank    <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
      busy             <= 1'b0;
      pix_cnt          <= '0;
      timer            <= '0;
    end else begin
      write_awaited <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state            <= S_GRANT;
            write_source_sel <= src_req;
            write_awaited    <= 1'b1;
            busy             <= 1'b1;
          end
        end
        S_GRANT: begin
          frame_error <= 1'b0;
          pix_cnt     <= '0;
          timer       <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (write_active) begin
            state <= S_STREAM;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            state       <= S_IDLE;
            frame_error <= 1'b1;
            busy        <= 1'b0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        S_STREAM: begin
          if (pixel_valid) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
          // act_d is high on entry, so a low act_d here is the falling edge of the stream.
          if (!act_d) begin
            state         <= S_COMMIT;
            frame_done    <= 1'b1;
            fb_front_bank <= ~fb_front_bank;
            if (pix_cnt != CNT_W'(NUM_PIX)) begin
              frame_error <= 1'b1;
            end
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
